// File: rtl/ltc_capture_pkg.sv
// Shared FSM encoding and counter-width helper for the LTC2207 burst capture path.
package ltc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ltc_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is valid the cycle after its push.
module ltc_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The extra pointer MSB separates a full buffer from an empty one.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ltc_burst_capture.sv
// LTC2207 burst capture: trigger synchroniser/edge detect, settle and decimation
// sequencing, and an FWFT sample buffer drained over a valid/ready stream.
module ltc_burst_capture
    import ltc_capture_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SETTLE      = 7,
    parameter int NUM_SAMPLES = 8,
    parameter int DECIM       = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              adc_clkout,
    input  logic              reset_n,
    input  logic              sample_in,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              overflow,
    input  logic              clear_ovf
);
    localparam int SET_W = cnt_width(SETTLE);
    localparam int DEC_W = cnt_width(DECIM);
    localparam int IDX_W = $clog2(NUM_SAMPLES + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(NUM_SAMPLES);

    logic             sync1_q, sync2_q, sync3_q;
    logic             trig;
    state_e           state_q, state_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;
    logic             capture, is_last, drop;
    logic             fifo_full, fifo_empty;
    logic [DATA_W:0]  fifo_head;

    always_ff @(posedge adc_clkout) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sample_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign trig = sync2_q & ~sync3_q;

    // One extra CAPTURE cycle after the final sample (idx == NUM_SAMPLES) before IDLE.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        dec_cnt_d = dec_cnt_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    set_cnt_d = '0;
                    dec_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (set_cnt_q == SET_LAST) state_d = ST_CAPTURE;
                else                       set_cnt_d = set_cnt_q + SET_W'(1);
            end
            ST_CAPTURE: begin
                if (idx_q == IDX_DONE) begin
                    state_d = ST_IDLE;
                end else begin
                    if (dec_cnt_q == '0) begin
                        capture = 1'b1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                    dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + DEC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign is_last = (idx_q == IDX_LAST);
    // A full buffer still accepts the word when the head is popped in the same cycle.
    assign drop    = capture & fifo_full & ~m_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (drop)           overflow_d = 1'b1;
        else if (clear_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge adc_clkout) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            set_cnt_q  <= '0;
            dec_cnt_q  <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    ltc_sample_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (adc_clkout),
        .rst_n     (reset_n),
        .push      (capture),
        .push_data ({is_last, din}),
        .full      (fifo_full),
        .pop       (m_ready),
        .pop_data  (fifo_head),
        .empty     (fifo_empty)
    );

    assign m_data   = fifo_head[DATA_W-1:0];
    assign m_last   = fifo_head[DATA_W];
    assign m_valid  = ~fifo_empty;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ltc_burst_capture.sv
// Bench for ltc_burst_capture: two configurations share one stimulus stream and are
// compared every cycle against an edge-indexed behavioural model.
module tb_ltc_burst_capture;
    localparam int DW = 16;
    localparam int NI = 2;
    typedef logic [DW:0] ent_t;

    // Instance 0: defaults. Instance 1: SETTLE=0, NUM_SAMPLES=4, DECIM=3, FIFO_DEPTH=4.
    function automatic int p_set(input int j); return (j == 0) ? 7 : 0;  endfunction
    function automatic int p_num(input int j); return (j == 0) ? 8 : 4;  endfunction
    function automatic int p_dec(input int j); return (j == 0) ? 1 : 3;  endfunction
    function automatic int p_dep(input int j); return (j == 0) ? 16 : 4; endfunction

    logic          clk = 1'b0;
    logic          reset_n, sample_in, m_ready, clear_ovf;
    logic [DW-1:0] din;
    logic [DW-1:0] m_data [NI];
    logic          m_valid [NI];
    logic          m_last [NI];
    logic          busy [NI];
    logic          overflow [NI];

    always #5 clk = ~clk;

    ltc_burst_capture #(
        .DATA_W(DW), .SETTLE(7), .NUM_SAMPLES(8), .DECIM(1), .FIFO_DEPTH(16)
    ) u_dut0 (
        .adc_clkout(clk), .reset_n(reset_n), .sample_in(sample_in), .din(din),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_last(m_last[0]),
        .busy(busy[0]), .overflow(overflow[0]), .clear_ovf(clear_ovf)
    );

    ltc_burst_capture #(
        .DATA_W(DW), .SETTLE(0), .NUM_SAMPLES(4), .DECIM(3), .FIFO_DEPTH(4)
    ) u_dut1 (
        .adc_clkout(clk), .reset_n(reset_n), .sample_in(sample_in), .din(din),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_last(m_last[1]),
        .busy(busy[1]), .overflow(overflow[1]), .clear_ovf(clear_ovf)
    );

    int   vectors = 0;
    int   errs    = 0;
    int   ecnt    = 4;
    bit   mdl_ok  = 1'b0;
    bit   sh [0:8191];
    ent_t mq [NI][$];
    ent_t lg [NI][$];
    int   b_start [NI] = '{-100, -100};
    int   b_end [NI]   = '{-100, -100};
    bit   mo_ovf [NI]  = '{1'b0, 1'b0};
    int   bc [NI]      = '{0, 0};
    ent_t hd;
    int   rdy_mode = 0;
    bit   rdy_val  = 1'b1;
    bit   ramp     = 1'b1;
    int   rdy_pct  = 50;

    task automatic check(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d] edge %0d: got 0x%0h, expected 0x%0h", nm, j, ecnt, act, exp);
        end
    endtask

    // Model: burst starting at trigger edge T captures at T+SETTLE+1+i*DECIM and is busy for
    // edges T..T+SETTLE+(N-1)*DECIM+1; the buffer is a bounded queue.
    task automatic model_step(input int j, input bit trig);
        int s, n, d, dep, off;
        bit cap, last, pop, full, drop;
        s    = p_set(j);
        n    = p_num(j);
        d    = p_dec(j);
        dep  = p_dep(j);
        off  = ecnt - b_start[j] - s - 1;
        cap  = (b_start[j] >= 0) && (off >= 0) && (off % d == 0) && (off / d < n);
        last = cap && (off / d == n - 1);
        pop  = (mq[j].size() > 0) && m_ready;
        full = (mq[j].size() == dep);
        drop = 1'b0;
        if (trig && ecnt > b_end[j]) begin
            b_start[j] = ecnt;
            b_end[j]   = ecnt + s + (n - 1) * d + 2;
        end
        if (pop) void'(mq[j].pop_front());
        if (cap) begin
            if (!full || pop) mq[j].push_back({last, din});
            else              drop = 1'b1;
        end
        if (drop)           mo_ovf[j] = 1'b1;
        else if (clear_ovf) mo_ovf[j] = 1'b0;
    endtask

    always @(posedge clk) begin
        ecnt++;
        if (!reset_n) begin
            sh[ecnt]     = 1'b0;
            sh[ecnt - 1] = 1'b0;
            sh[ecnt - 2] = 1'b0;
            for (int j = 0; j < NI; j++) begin
                mq[j].delete();
                mo_ovf[j]  = 1'b0;
                b_start[j] = -100;
                b_end[j]   = -100;
            end
        end else begin
            sh[ecnt] = sample_in;
            for (int j = 0; j < NI; j++) model_step(j, sh[ecnt - 2] && !sh[ecnt - 3]);
        end
        mdl_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            for (int j = 0; j < NI; j++) begin
                hd = '0;
                if (mq[j].size() > 0) hd = mq[j][0];
                check("m_valid", j, 32'(m_valid[j]), 32'(mq[j].size() > 0));
                check("m_data", j, 32'(m_data[j]), 32'(hd[DW-1:0]));
                check("m_last", j, 32'(m_last[j]), 32'(hd[DW]));
                check("busy", j, 32'(busy[j]), 32'((ecnt >= b_start[j]) && (ecnt < b_end[j])));
                check("overflow", j, 32'(overflow[j]), 32'(mo_ovf[j]));
                if (m_valid[j] && m_ready) lg[j].push_back({m_last[j], m_data[j]});
                if (busy[j]) bc[j]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        din = ramp ? DW'(ecnt) : DW'($urandom);
        case (rdy_mode)
            0:       m_ready = rdy_val;
            1:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(0, 99) < rdy_pct);
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Raise sample_in for hi edges; p is the edge before the first high sample (E0 = p+1).
    task automatic fire(input int hi, output int p);
        tick();
        p = ecnt;
        sample_in = 1'b1;
        repeat (hi) tick();
        sample_in = 1'b0;
    endtask

    task automatic clear_logs();
        for (int j = 0; j < NI; j++) begin
            lg[j].delete();
            bc[j] = 0;
        end
    endtask

    initial begin
        int   p, p2, lasts;
        ent_t e;
        reset_n = 1'b0; sample_in = 1'b0; din = '0; m_ready = 1'b1; clear_ovf = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(4);
        for (int j = 0; j < NI; j++) begin
            check("rst_valid", j, 32'(m_valid[j]), 32'd0);
            check("rst_data", j, 32'(m_data[j]), 32'd0);
            check("rst_busy", j, 32'(busy[j]), 32'd0);
            check("rst_ovf", j, 32'(overflow[j]), 32'd0);
        end

        // Single burst with ramp data and a 3-cycle trigger pulse.
        clear_logs();
        fire(3, p);
        idle(30);
        check("burst_busy_cycles", 0, bc[0], 16);
        check("burst_busy_cycles", 1, bc[1], 11);
        check("burst_words", 0, lg[0].size(), 8);
        check("burst_words", 1, lg[1].size(), 4);
        if (lg[0].size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                e = lg[0][i];
                check("ramp_word", 0, 32'(e[DW-1:0]), 32'(p + 10 + i));
                check("ramp_last", 0, 32'(e[DW]), 32'(i == 7));
            end
        end
        if (lg[1].size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                e = lg[1][i];
                check("decim_word", 1, 32'(e[DW-1:0]), 32'(p + 3 + 3 * i));
                check("decim_last", 1, 32'(e[DW]), 32'(i == 3));
            end
        end

        // Stalled sink: third burst overflows instance 0, second burst overflows instance 1.
        clear_logs();
        rdy_val = 1'b0;
        repeat (3) begin
            fire(2, p);
            idle(25);
        end
        check("ovf_set", 0, 32'(overflow[0]), 32'd1);
        check("ovf_set", 1, 32'(overflow[1]), 32'd1);
        check("ovf_idle", 0, 32'(busy[0]), 32'd0);
        rdy_val = 1'b1;
        idle(25);
        check("drain_words", 0, lg[0].size(), 16);
        check("drain_words", 1, lg[1].size(), 4);
        lasts = 0;
        foreach (lg[0][i]) begin
            e = lg[0][i];
            if (e[DW]) lasts++;
        end
        check("drain_lasts", 0, lasts, 2);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_clear", 0, 32'(overflow[0]), 32'd0);
        check("ovf_clear", 1, 32'(overflow[1]), 32'd0);

        // Retrigger during a burst, then a long high level: one burst each.
        clear_logs();
        fire(2, p);
        idle(5);
        fire(2, p);
        idle(30);
        check("retrig_words", 0, lg[0].size(), 8);
        check("retrig_words", 1, lg[1].size(), 4);
        fire(40, p);
        idle(10);
        check("held_words", 0, lg[0].size(), 16);
        check("held_words", 1, lg[1].size(), 8);

        // Reset for one cycle after three pushes into a stalled buffer.
        clear_logs();
        rdy_val = 1'b0;
        fire(2, p);
        while (ecnt < p + 13) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int j = 0; j < NI; j++) begin
            check("abort_valid", j, 32'(m_valid[j]), 32'd0);
            check("abort_busy", j, 32'(busy[j]), 32'd0);
            check("abort_ovf", j, 32'(overflow[j]), 32'd0);
        end
        rdy_val = 1'b1;
        idle(3);
        fire(2, p);
        idle(30);
        check("fresh_words", 0, lg[0].size(), 8);
        check("fresh_words", 1, lg[1].size(), 4);

        // Sink ready toggling every cycle across two back-to-back bursts.
        clear_logs();
        rdy_mode = 1;
        fire(2, p);
        idle(20);
        fire(2, p2);
        idle(45);
        check("toggle_words", 0, lg[0].size(), 16);
        check("toggle_ovf", 0, 32'(overflow[0]), 32'd0);
        if (lg[0].size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                e = lg[0][i];
                check("toggle_word", 0, 32'(e[DW-1:0]), 32'((i < 8) ? p + 10 + i : p2 + 2 + i));
                check("toggle_last", 0, 32'(e[DW]), 32'(i == 7 || i == 15));
            end
        end

        // Randomised traffic with occasional resets and overflow clears.
        ramp = 1'b0;
        rdy_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) rdy_pct = $urandom_range(0, 100);
            tick();
            if ($urandom_range(0, 7) == 0) sample_in = ~sample_in;
            clear_ovf = ($urandom_range(0, 39) == 0);
            reset_n   = ($urandom_range(0, 599) != 0);
        end
        reset_n = 1'b1; clear_ovf = 1'b0; sample_in = 1'b0;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
